// File: rtl/asm_feeder.sv
// rtl/asm_feeder.sv - job sequencer that streams pixel/weight beats into one ASM lane
module asm_feeder #(
    parameter int BN_WIDTH = 16,
    parameter int KLEN     = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BN_WIDTH-1:0]   in_bn,
    input  logic [KLEN-1:0]       in_weight,
    input  logic [8*KLEN-1:0]     in_pix,
    input  logic                  hold,
    output logic                  calculate_en,
    output logic [1:0]            data_pix,
    output logic                  data_weight,
    output logic [BN_WIDTH-1:0]   data_bn,
    output logic                  asm_reception,
    output logic                  asm_change,
    input  logic                  asm_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit
);

    localparam int BW = (KLEN > 1) ? $clog2(KLEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(KLEN - 1);
    localparam logic [1:0]    PAD_CODE  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t              state;
    logic [8*KLEN-1:0]   pix_q;     // consumed from the bottom, two bits per presented beat
    logic [KLEN-1:0]     weight_q;  // rotated so bit 0 is always the weight of the next beat
    logic [BW-1:0]       beat;
    logic [1:0]          phase;
    logic                done;      // all 4*KLEN beats have been presented
    logic                present;

    // A beat goes out on the edge leaving PRIME and on every RUN edge that is neither stalled nor finished
    assign present  = (state == S_PRIME) || ((state == S_RUN) && !done && !hold);
    assign in_ready = (state == S_IDLE);

    // Job FSM with registered ASM-facing and result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            pix_q         <= '0;
            weight_q      <= '0;
            beat          <= '0;
            phase         <= '0;
            done          <= 1'b0;
            calculate_en  <= 1'b0;
            data_pix      <= PAD_CODE;
            data_weight   <= 1'b0;
            data_bn       <= '0;
            asm_reception <= 1'b0;
            asm_change    <= 1'b0;
            out_valid     <= 1'b0;
            out_bit       <= 1'b0;
        end else begin
            data_pix      <= PAD_CODE;
            data_weight   <= 1'b0;
            asm_change    <= 1'b0;
            asm_reception <= 1'b0;

            if (present) begin
                data_pix      <= pix_q[1:0];
                data_weight   <= weight_q[0];
                asm_change    <= (beat == LAST_BEAT);
                asm_reception <= (phase == 2'd0) && (beat == '0);
                pix_q         <= pix_q >> 2;
                weight_q      <= (weight_q >> 1) | (weight_q << (KLEN - 1));
                if (beat == LAST_BEAT) begin
                    beat  <= '0;
                    phase <= phase + 2'd1;
                    if (phase == 2'd3) begin
                        done <= 1'b1;
                    end
                end else begin
                    beat <= beat + BW'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state        <= S_PRIME;
                        pix_q        <= in_pix;
                        weight_q     <= in_weight;
                        beat         <= '0;
                        phase        <= '0;
                        done         <= 1'b0;
                        calculate_en <= 1'b1;
                        data_bn      <= in_bn;
                    end
                end
                S_PRIME: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (done) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    state        <= S_DRAIN;
                    out_bit      <= asm_out;
                    out_valid    <= 1'b1;
                    calculate_en <= 1'b0;
                    data_bn      <= '0;
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        out_bit   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asm_feeder.sv
// tb/tb_asm_feeder.sv - self-checking bench for asm_feeder with a flat-index beat model
module tb_asm_feeder;

    localparam int BNW = 16;
    localparam int K   = 9;
    localparam int NB  = 4 * K;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [BNW-1:0]   in_bn = '0;
    logic [K-1:0]     in_weight = '0;
    logic [8*K-1:0]   in_pix = '0;
    logic             hold = 1'b0;
    logic             calculate_en;
    logic [1:0]       data_pix;
    logic             data_weight;
    logic [BNW-1:0]   data_bn;
    logic             asm_reception;
    logic             asm_change;
    logic             asm_out = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_bit;

    int tests = 0;
    int fails = 0;

    logic [BNW-1:0]   j_bn;
    logic [K-1:0]     j_w;
    logic [8*K-1:0]   j_pix;
    bit               hold_pat [0:255];
    int               wait_cycles;

    always #5 clk = ~clk;

    asm_feeder #(.BN_WIDTH(BNW), .KLEN(K)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bn        (in_bn),
        .in_weight    (in_weight),
        .in_pix       (in_pix),
        .hold         (hold),
        .calculate_en (calculate_en),
        .data_pix     (data_pix),
        .data_weight  (data_weight),
        .data_bn      (data_bn),
        .asm_reception(asm_reception),
        .asm_change   (asm_change),
        .asm_out      (asm_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bit      (out_bit)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result the ASM produces: max over the four phase sums, compared strictly above the BN threshold
    function automatic logic ref_result();
        int mx = -1000;
        for (int p = 0; p < 4; p++) begin
            int s = 0;
            for (int k = 0; k < K; k++) begin
                logic [1:0] code = j_pix[2*(p*K+k) +: 2];
                if (code != 2'b10) s += (j_w[k] == code[0]) ? 1 : -1;
            end
            if (s > mx) mx = s;
        end
        return logic'(mx > int'($signed(j_bn)));
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_calc_en"}, calculate_en, 0);
        chk({tag, "_pix"}, data_pix, 2'b10);
        chk({tag, "_weight"}, data_weight, 0);
        chk({tag, "_change"}, asm_change, 0);
        chk({tag, "_reception"}, asm_reception, 0);
        chk({tag, "_bn"}, data_bn, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_bit"}, out_bit, 0);
    endtask

    task automatic clear_hold();
        for (int i = 0; i < 256; i++) hold_pat[i] = 1'b0;
    endtask

    task automatic random_job();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        j_pix = r[8*K-1:0];
        r = {$urandom, $urandom, $urandom, $urandom};
        j_w = r[K-1:0];
        j_bn = BNW'($urandom_range(0, 8)) - BNW'(4);
    endtask

    // Present the descriptor and return #1 after the accept edge
    task automatic start_job();
        logic [127:0] r;
        @(negedge clk);
        wait_cycles = 0;
        while (in_ready !== 1'b1 && wait_cycles < 50) begin
            @(negedge clk);
            wait_cycles++;
        end
        chk("ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        in_bn     = j_bn;
        in_weight = j_w;
        in_pix    = j_pix;
        hold      = 1'b0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        r = {$urandom, $urandom, $urandom, $urandom};
        in_pix    = r[8*K-1:0];
        in_weight = r[K-1:0];
        in_bn     = r[BNW-1:0];
    endtask

    // Walk PRIME, RUN, CAPTURE and DRAIN cycle by cycle against the flat beat model
    task automatic run_job(input int rdy_delay);
        logic res;
        int   idx;
        bit   prev_hold;
        bit   captured;
        res = ref_result();
        @(negedge clk);
        chk("prime_calc_en", calculate_en, 1);
        chk("prime_pix", data_pix, 2'b10);
        chk("prime_bn", data_bn, j_bn);
        chk("prime_in_ready", in_ready, 0);
        chk("prime_valid", out_valid, 0);
        hold = 1'b0;
        asm_out = ~res;
        idx = 0;
        prev_hold = 1'b0;
        captured = 1'b0;
        for (int c = 1; c < 4 * NB; c++) begin
            @(negedge clk);
            if (idx == NB) begin
                chk("cap_calc_en", calculate_en, 1);
                chk("cap_pix", data_pix, 2'b10);
                chk("cap_change", asm_change, 0);
                chk("cap_bn", data_bn, j_bn);
                chk("cap_valid", out_valid, 0);
                asm_out  = res;
                hold     = 1'($urandom);
                in_valid = 1'($urandom);
                captured = 1'b1;
                break;
            end
            chk("run_calc_en", calculate_en, 1);
            chk("run_valid", out_valid, 0);
            chk("run_bn", data_bn, j_bn);
            chk("run_in_ready", in_ready, 0);
            if (prev_hold) begin
                chk("bubble_pix", data_pix, 2'b10);
                chk("bubble_change", asm_change, 0);
                chk("bubble_reception", asm_reception, 0);
            end else begin
                chk("beat_pix", data_pix, j_pix[2*idx +: 2]);
                chk("beat_weight", data_weight, j_w[idx % K]);
                chk("beat_change", asm_change, ((idx % K) == K - 1) ? 1 : 0);
                chk("beat_reception", asm_reception, (idx == 0) ? 1 : 0);
                idx++;
            end
            prev_hold = hold_pat[c];
            hold      = hold_pat[c];
            asm_out   = ~res;
            in_valid  = 1'($urandom);
        end
        chk("capture_reached", captured, 1);
        for (int d = 0; d <= rdy_delay; d++) begin
            @(negedge clk);
            chk("drain_valid", out_valid, 1);
            chk("drain_bit", out_bit, res);
            chk("drain_calc_en", calculate_en, 0);
            chk("drain_in_ready", in_ready, 0);
            chk("drain_pix", data_pix, 2'b10);
            chk("drain_bn", data_bn, 0);
            asm_out   = 1'($urandom);
            in_valid  = 1'($urandom);
            out_ready = (d == rdy_delay);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        hold      = 1'b0;
    endtask

    initial begin
        clear_hold();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("in_reset");
        rst = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_idle("idle");
        end

        // All-ones weights with code 01: every product +1
        j_bn = '0; j_w = '1; j_pix = {K{8'h55}};
        chk("ref_sum9", ref_result(), 1);
        start_job();
        run_job(0);

        // All padding: every product 0
        j_pix = {K{8'haa}};
        chk("ref_pad", ref_result(), 0);
        start_job();
        run_job(0);

        // Hold on beats 3, 4 and on phase 2 beat 8
        j_pix = {K{8'h55}};
        clear_hold();
        hold_pat[4] = 1'b1; hold_pat[5] = 1'b1; hold_pat[29] = 1'b1;
        start_job();
        run_job(0);
        clear_hold();

        // Slow consumer, then a back-to-back job
        random_job();
        start_job();
        run_job(5);
        random_job();
        start_job();
        chk("b2b_no_wait", wait_cycles, 0);
        run_job(0);

        // Reset in the middle of RUN
        random_job();
        start_job();
        repeat (21) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_no_valid", out_valid, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");
        random_job();
        start_job();
        run_job(1);

        // Random jobs with random stalls and consumer delays
        for (int n = 0; n < 8; n++) begin
            random_job();
            for (int c = 1; c < 256; c++) hold_pat[c] = ($urandom_range(0, 4) == 0);
            start_job();
            run_job(int'($urandom_range(0, 3)));
        end
        clear_hold();

        @(negedge clk);
        chk_idle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
